hazard_ctrl: RTL
================

# hazard_ctrl

Consumer end of the decode-stage Tuse/A3 interface. It keeps a shadow pipeline of destination register and Tnew for the E, M and W stages, and compares the D-stage instruction's Tuse and source registers against it. From that it raises a stall, inserts a bubble into E, and produces forwarding selects for the D-stage (branch/jr) and E-stage (ALU) operands. It sits beside the pipeline registers in the 5-stage MIPS core.

## Interface
- `TNEW_W`, default 2: width of the Tuse/Tnew fields. A value of 3 means "not used / no result".
- `REG_AW`, default 5: register address width.
- `clk` in 1: single core clock. All state is updated on the rising edge.
- `reset` in 1: synchronous, active-high. Clears every slot.
- `Tuse_rs_D`, `Tuse_rt_D` in 2: cycles until the D instruction needs rs/rt.
- `rs_D`, `rt_D` in 5: D-stage source register addresses.
- `A3_D` in 5: D-stage destination register; 0 means no write.
- `Tnew_D` in 2: cycles after entering E until the result exists (lw=2, ALU/lui=1, jal=0).
- `stall` out 1: freeze PC and the F/D register this cycle.
- `fwd_rs_D`, `fwd_rt_D` out 2: D-operand source. 0 = RF, 1 = E, 2 = M, 3 = W.
- `fwd_rs_E`, `fwd_rt_E` out 2: E-operand source. 0 = RF value latched in E, 2 = M, 3 = W. Value 1 is never driven.
- `stall_cnt` out 32: only present with `HAZARD_STATS_EN`.

## Operation
**Slots.** E, M and W each hold `{A3, Tnew, rs, rt}`. M and W hold rs/rt only for debug.

**Advance each cycle:**
- W ← M, with Tnew forced to 0.
- M ← E, with Tnew = max(Tnew_E − 1, 0).
- If `stall` = 0: E ← `{A3_D, Tnew_D, rs_D, rt_D}`.
- If `stall` = 1: E ← bubble `{0,0,0,0}`.

**Match.** `hit(X, r)` = (r ≠ 0) && (A3_X == r).

**Stall** (combinational). Asserted when either:
- (hit(E, rs_D) && Tuse_rs_D < Tnew_E) || (hit(M, rs_D) && Tuse_rs_D < Tnew_M), or
- the same condition for rt_D.

Tuse = 3 never stalls.

**D forwarding.** For each operand, take the first matching source in this order:
1. hit(E) && Tnew_E == 0 → 1
2. hit(M) && Tnew_M == 0 → 2
3. hit(W) → 3
4. otherwise → 0

A hit with nonzero Tnew selects nothing at that level and falls through. Correctness in that case relies on `stall`.

**E forwarding.** Uses rs_E/rt_E.
1. hit(M) && Tnew_M == 0 → 2
2. hit(W) → 3
3. otherwise → 0

**Boundary conditions:**
- `$0` never matches, so writes to `$0` are never forwarded.
- If E and M both match, E wins.
- Stalls repeat back to back until Tnew drains; the D inputs stay held by the upstream freeze.

## Timing
- `stall` and all `fwd_*` outputs are combinational from the current slots and the D inputs. Latency is 0 cycles.
- Slots update one cycle after the inputs are sampled.
- Maximum stall is 2 cycles (lw in E followed by beq with Tuse = 0).
- After `reset`, all slots are 0, so `stall` = 0, all `fwd_*` = 0 and `stall_cnt` = 0.
- Reset asserted mid-stall clears the slots at the next edge. `stall` then drops in the following cycle.

## Configuration
- `HAZARD_STATS_EN` defined: a 32-bit `stall_cnt` port is present. It increments on every edge where `stall` = 1 and `reset` = 0, and wraps from 0xFFFFFFFF to 0.
- `HAZARD_STATS_EN` undefined: the port and the counter are absent. Hazard behaviour is identical.

## Structure
- Shared package `pipe_pkg` holds:
  - the `FWD_RF`/`FWD_E`/`FWD_M`/`FWD_W` encodings (0–3);
  - `TUSE_NONE` = 3;
  - the slot struct `{A3, Tnew, rs, rt}`.
- One sub-module, `hazard_slot`: a registered slot with load, bubble and Tnew-decrement controls. It is instantiated three times (E, M, W).

## Test plan
- Load-use: lw $8 (A3=8, Tnew_D=2) into E, then addu using rs=8 with Tuse=1. Expect `stall`=1 for exactly 1 cycle, then `fwd_rs_E`=3 (W) once addu is in E.
- Branch after lw: lw $8, then beq with rs=8, Tuse=0. Expect `stall`=1 for 2 cycles, then `fwd_rs_D`=3.
- ALU then branch: ori $5 (Tnew=1), then beq rs=5. Expect 1 stall cycle, then `fwd_rs_D`=2.
- jal then jr $31: jal (A3=31, Tnew=0), then jr. Expect no stall and `fwd_rs_D`=1.
- `$0` and priority:
  - addu writing $0, followed by a reader of $0. Expect `fwd`=0 and no stall.
  - Writes to $9 from both E (Tnew=0) and M. Expect `fwd_rs_D`=1.
- Reset during a stall: assert `reset` while lw $8 is in E and `stall`=1. Next cycle expect `stall`=0 and all `fwd`=0. Under `HAZARD_STATS_EN`, expect `stall_cnt`=0, and 3 subsequent stall cycles read as 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the decode-stage hazard logic of the 5-stage MIPS
// core. It holds the forwarding-select encodings, the "operand not used"
// Tuse value, and the shadow-pipeline slot record {A3, Tnew, rs, rt}.
// The slot field widths are fixed here. hazard_ctrl's TNEW_W/REG_AW
// parameters default to these widths and are expected to stay equal to them.
// ---------------------------------------------------------------------------
package pipe_pkg;

   localparam int SLOT_TNEW_W = 2;
   localparam int SLOT_AW     = 5;

   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_E  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;
   localparam logic [1:0] FWD_W  = 2'd3;

   localparam logic [SLOT_TNEW_W-1:0] TUSE_NONE = 2'd3;

   typedef struct packed {
      logic [SLOT_AW-1:0]     a3;
      logic [SLOT_TNEW_W-1:0] tnew;
      logic [SLOT_AW-1:0]     rs;
      logic [SLOT_AW-1:0]     rt;
   } slot_t;

   // A source register matches a slot only when it is a real register.
   // $0 never matches, so writes to $0 are never forwarded or waited on.
   function automatic logic reg_hit(input logic [SLOT_AW-1:0] a3,
                                    input logic [SLOT_AW-1:0] r);
      return (r != '0) && (a3 == r);
   endfunction

endpackage

// File: rtl/hazard_slot.sv
// ---------------------------------------------------------------------------
// hazard_slot
// One registered stage of the shadow pipeline (used for E, M and W).
// Ports:
//   clk, reset  - core clock; synchronous active-high reset clears the slot
//   d           - incoming slot record from the previous stage
//   load        - capture the incoming record (otherwise hold)
//   bubble      - capture an all-zero bubble instead of d
//   dec_tnew    - decrement the incoming Tnew, saturating at 0
//   clr_tnew    - force the incoming Tnew to 0
//   q           - current slot contents
// ---------------------------------------------------------------------------
module hazard_slot
   import pipe_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  slot_t d,
   input  logic  load,
   input  logic  bubble,
   input  logic  dec_tnew,
   input  logic  clr_tnew,
   output slot_t q
);

   slot_t nxt;

   // Build the record this slot will hold after the edge. A bubble overrides
   // everything. Otherwise the Tnew of the incoming record is aged: it is
   // either cleared, or counted down by one without going below zero.
   always_comb begin
      nxt = d;
      if (clr_tnew) begin
         nxt.tnew = '0;
      end else if (dec_tnew && (d.tnew != '0)) begin
         nxt.tnew = d.tnew - SLOT_TNEW_W'(1);
      end
      if (bubble) begin
         nxt = '0;
      end
   end

   // The slot register. Reset empties it (A3 = 0 means "no write").
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= nxt;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Decode-stage hazard unit. It keeps a shadow pipeline of {A3, Tnew, rs, rt}
// for E, M and W and compares it with the D-stage instruction. From that it
// raises a stall (which also bubbles E) and forwarding selects.
// Ports:
//   clk, reset              - core clock; synchronous active-high reset
//   Tuse_rs_D, Tuse_rt_D    - cycles until D needs rs/rt (3 = not used)
//   rs_D, rt_D              - D-stage source registers
//   A3_D, Tnew_D            - D-stage destination and result latency
//   stall                   - freeze PC and F/D this cycle
//   fwd_rs_D, fwd_rt_D      - D operand source: 0 RF, 1 E, 2 M, 3 W
//   fwd_rs_E, fwd_rt_E      - E operand source: 0 RF, 2 M, 3 W
//   stall_cnt               - stall-cycle counter, only with HAZARD_STATS_EN
// Optional feature macro: HAZARD_STATS_EN
// ---------------------------------------------------------------------------
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int TNEW_W = SLOT_TNEW_W,
   parameter int REG_AW = SLOT_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [TNEW_W-1:0] Tuse_rs_D,
   input  logic [TNEW_W-1:0] Tuse_rt_D,
   input  logic [REG_AW-1:0] rs_D,
   input  logic [REG_AW-1:0] rt_D,
   input  logic [REG_AW-1:0] A3_D,
   input  logic [TNEW_W-1:0] Tnew_D,
   output logic              stall,
   output logic [1:0]        fwd_rs_D,
   output logic [1:0]        fwd_rt_D,
   output logic [1:0]        fwd_rs_E,
   output logic [1:0]        fwd_rt_E
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   slot_t d_slot;
   slot_t slot_e;
   slot_t slot_m;
   slot_t slot_w;

   // An operand stalls when a producer in E or M will not have its result
   // ready by the time D needs it. Tuse = 3 means the operand is unused.
   function automatic logic src_stall(input logic [SLOT_TNEW_W-1:0] tuse,
                                      input logic [SLOT_AW-1:0] r,
                                      input slot_t e, input slot_t m);
      return (tuse != TUSE_NONE) &&
             ((reg_hit(e.a3, r) && (tuse < e.tnew)) ||
              (reg_hit(m.a3, r) && (tuse < m.tnew)));
   endfunction

   // D-operand select, nearest ready producer first. A hit whose result is
   // not ready yet selects nothing at that level; the stall covers it.
   function automatic logic [1:0] fwd_d(input logic [SLOT_AW-1:0] r,
                                        input slot_t e, input slot_t m,
                                        input slot_t w);
      if (reg_hit(e.a3, r) && (e.tnew == '0)) return FWD_E;
      if (reg_hit(m.a3, r) && (m.tnew == '0)) return FWD_M;
      if (reg_hit(w.a3, r))                   return FWD_W;
      return FWD_RF;
   endfunction

   // E-operand select. Only M and W can supply a value to the ALU.
   function automatic logic [1:0] fwd_e(input logic [SLOT_AW-1:0] r,
                                        input slot_t m, input slot_t w);
      if (reg_hit(m.a3, r) && (m.tnew == '0)) return FWD_M;
      if (reg_hit(w.a3, r))                   return FWD_W;
      return FWD_RF;
   endfunction

   // Pack the D-stage instruction into a slot record for the E stage.
   always_comb begin
      d_slot      = '0;
      d_slot.a3   = A3_D;
      d_slot.tnew = Tnew_D;
      d_slot.rs   = rs_D;
      d_slot.rt   = rt_D;
   end

   // E takes the D instruction, or a bubble while D is frozen by a stall.
   hazard_slot u_slot_e (
      .clk      (clk),
      .reset    (reset),
      .d        (d_slot),
      .load     (1'b1),
      .bubble   (stall),
      .dec_tnew (1'b0),
      .clr_tnew (1'b0),
      .q        (slot_e)
   );

   // M takes E with its result one cycle closer to ready.
   hazard_slot u_slot_m (
      .clk      (clk),
      .reset    (reset),
      .d        (slot_e),
      .load     (1'b1),
      .bubble   (1'b0),
      .dec_tnew (1'b1),
      .clr_tnew (1'b0),
      .q        (slot_m)
   );

   // W takes M. Every result has been produced by the time it reaches W.
   hazard_slot u_slot_w (
      .clk      (clk),
      .reset    (reset),
      .d        (slot_m),
      .load     (1'b1),
      .bubble   (1'b0),
      .dec_tnew (1'b0),
      .clr_tnew (1'b1),
      .q        (slot_w)
   );

   // All hazard outputs are combinational from the slots and the D inputs.
   always_comb begin
      stall    = src_stall(Tuse_rs_D, rs_D, slot_e, slot_m) ||
                 src_stall(Tuse_rt_D, rt_D, slot_e, slot_m);
      fwd_rs_D = fwd_d(rs_D, slot_e, slot_m, slot_w);
      fwd_rt_D = fwd_d(rt_D, slot_e, slot_m, slot_w);
      fwd_rs_E = fwd_e(slot_e.rs, slot_m, slot_w);
      fwd_rt_E = fwd_e(slot_e.rt, slot_m, slot_w);
   end

`ifdef HAZARD_STATS_EN
   // Count every cycle spent stalled. Reset takes priority over counting,
   // and the counter wraps naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
